// File: rtl/ftdi_fifo_emu_if.sv
// FT232H sync-245 FIFO bus between the FPGA-side master and the emulated chip.
// master = FPGA logic, slave = device model (drives flags and read data).
interface ftdi_fifo_emu_if;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       rxf_n;
    logic       txe_n;
    logic       rd_n;
    logic       oe_n;
    logic       wr_n;

    modport master (
        input  data_out, data_oe, rxf_n, txe_n,
        output data_in, rd_n, oe_n, wr_n
    );

    modport slave (
        output data_out, data_oe, rxf_n, txe_n,
        input  data_in, rd_n, oe_n, wr_n
    );
endinterface

// File: rtl/ftdi_fifo_emu.sv
// Device-side FT232H sync-245 FIFO model with a host stream port standing in for USB.
// Optional FTDI_EMU_THROTTLE_EN: LFSR-driven backpressure on rxf_n/txe_n.
module ftdi_fifo_emu #(
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    ftdi_fifo_emu_if.slave bus,
    input  logic [7:0] host_tx_din,
    input  logic       host_tx_dv,
    output logic       host_tx_rdy,
    output logic [7:0] host_rx_dout,
    output logic       host_rx_dv,
    input  logic       host_rx_rdy,
    output logic       err_underrun,
    output logic       err_overrun,
    output logic       err_rd_no_oe
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);

    logic [7:0]   rx_mem [RX_DEPTH];
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [RAW:0] rx_cnt;
    logic [TAW:0] tx_cnt;

    logic thr_rx, thr_tx;
    logic rx_push, rx_pop, tx_push, tx_pop;

`ifdef FTDI_EMU_THROTTLE_EN
    logic [15:0] lfsr;

    // Galois form of x^16+x^14+x^13+x^11, shifting right
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign thr_rx = lfsr[0];
    assign thr_tx = lfsr[1];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign thr_rx = 1'b0;
    assign thr_tx = 1'b0;
`endif

    // Reset gating keeps every flag at its idle value while reset is held
    assign bus.rxf_n   = reset | (rx_cnt == '0) | thr_rx;
    assign bus.txe_n   = reset | (tx_cnt == TX_FULL) | thr_tx;
    assign host_tx_rdy = ~reset & (rx_cnt != RX_FULL);
    assign host_rx_dv  = ~reset & (tx_cnt != '0);

    assign bus.data_out = rx_mem[rx_rp];
    assign bus.data_oe  = ~bus.oe_n;
    assign host_rx_dout = tx_mem[tx_rp];

    assign rx_push = host_tx_dv & host_tx_rdy;
    assign rx_pop  = ~bus.rd_n & ~bus.oe_n & ~bus.rxf_n;
    assign tx_push = ~bus.wr_n & ~bus.txe_n;
    assign tx_pop  = host_rx_dv & host_rx_rdy;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= host_tx_din;
        if (tx_push) tx_mem[tx_wp] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;
            err_rd_no_oe <= 1'b0;
        end else begin
            if (~bus.rd_n & bus.rxf_n) err_underrun <= 1'b1;
            if (~bus.wr_n & bus.txe_n) err_overrun  <= 1'b1;
            if (~bus.rd_n & bus.oe_n)  err_rd_no_oe <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ftdi_fifo_emu.sv
// Scoreboard bench for ftdi_fifo_emu: directed FTDI/host traffic then random mix.
// A queue-based occupancy model predicts flags, errors and byte order.
module tb_ftdi_fifo_emu;
    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] host_tx_din = 8'h00;
    logic       host_tx_dv = 1'b0;
    logic       host_tx_rdy;
    logic [7:0] host_rx_dout;
    logic       host_rx_dv;
    logic       host_rx_rdy = 1'b0;
    logic       err_underrun, err_overrun, err_rd_no_oe;

    ftdi_fifo_emu_if bus();

    ftdi_fifo_emu #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .host_tx_din(host_tx_din), .host_tx_dv(host_tx_dv), .host_tx_rdy(host_tx_rdy),
        .host_rx_dout(host_rx_dout), .host_rx_dv(host_rx_dv), .host_rx_rdy(host_rx_rdy),
        .err_underrun(err_underrun), .err_overrun(err_overrun), .err_rd_no_oe(err_rd_no_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy, in-flight bytes, sticky errors, throttle LFSR
    int          rx_n = 0;
    int          tx_n = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  tx_q [$];
    logic [15:0] lfsr_m = SEED;
    bit          e_und = 0, e_ovr = 0, e_noe = 0;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit thr_rx();
`ifdef FTDI_EMU_THROTTLE_EN
        return lfsr_m[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit thr_tx();
`ifdef FTDI_EMU_THROTTLE_EN
        return lfsr_m[1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit rxf_exp();
        return reset || rx_n == 0 || thr_rx();
    endfunction

    function automatic bit txe_exp();
        return reset || tx_n == TXD || thr_tx();
    endfunction

    // Model update on each active edge from the pre-edge inputs
    initial begin
        forever begin
            bit rf, tf, rpush, rpop, tpush, tpop;
            @(posedge clk);
            rf = rxf_exp();
            tf = txe_exp();
            if (reset) begin
                rx_n = 0;
                tx_n = 0;
                rx_q.delete();
                tx_q.delete();
                lfsr_m = SEED;
                e_und = 0;
                e_ovr = 0;
                e_noe = 0;
            end else begin
                rpop  = !bus.rd_n && !bus.oe_n && !rf;
                rpush = host_tx_dv && rx_n < RXD;
                tpush = !bus.wr_n && !tf;
                tpop  = host_rx_rdy && tx_n > 0;
                if (!bus.rd_n && rf) e_und = 1;
                if (!bus.wr_n && tf) e_ovr = 1;
                if (!bus.rd_n && bus.oe_n) e_noe = 1;
                if (rpush) rx_q.push_back(host_tx_din);
                if (tpush) tx_q.push_back(bus.data_in);
                rx_n = rx_n + int'(rpush) - int'(rpop);
                tx_n = tx_n + int'(tpush) - int'(tpop);
                lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
            end
        end
    end

    // Monitor: flags every cycle, data whenever a byte leaves either FIFO
    initial begin
        forever begin
            @(negedge clk);
            chk("rxf_n", 8'(bus.rxf_n), 8'(rxf_exp()));
            chk("txe_n", 8'(bus.txe_n), 8'(txe_exp()));
            chk("host_tx_rdy", 8'(host_tx_rdy), 8'(!reset && rx_n < RXD));
            chk("host_rx_dv", 8'(host_rx_dv), 8'(!reset && tx_n > 0));
            chk("data_oe", 8'(bus.data_oe), 8'(!bus.oe_n));
            chk("err_underrun", 8'(err_underrun), 8'(e_und));
            chk("err_overrun", 8'(err_overrun), 8'(e_ovr));
            chk("err_rd_no_oe", 8'(err_rd_no_oe), 8'(e_noe));
            if (!reset && !bus.rd_n && !bus.oe_n && !rxf_exp()) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_data: pop with empty scoreboard at %0t", $time);
                end else begin
                    chk("rx_data", bus.data_out, rx_q.pop_front());
                end
            end
            if (!reset && host_rx_rdy && tx_n > 0) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_data: pop with empty scoreboard at %0t", $time);
                end else begin
                    chk("tx_data", host_rx_dout, tx_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.data_in = 8'h00;
        repeat (3) step();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            host_tx_dv = 1'b1;
            host_tx_din = 8'h11 + 8'(i);
            step();
`ifndef FTDI_EMU_THROTTLE_EN
            if (i == 0) chk("rxf_after_push", 8'(bus.rxf_n), 8'h00);
`endif
        end
        host_tx_dv = 1'b0;
`ifndef FTDI_EMU_THROTTLE_EN
        chk("fwft_head", bus.data_out, 8'h11);
`endif
        bus.oe_n = 1'b0;
        step();
        bus.rd_n = 1'b0;
        repeat (4) step();
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
`ifndef FTDI_EMU_THROTTLE_EN
        chk("rxf_after_drain", 8'(bus.rxf_n), 8'h01);
        chk("no_underrun", 8'(err_underrun), 8'h00);
`endif

        for (int i = 0; i < 16; i++) begin
            bus.wr_n = 1'b0;
            bus.data_in = 8'(i);
            step();
        end
`ifndef FTDI_EMU_THROTTLE_EN
        chk("txe_full", 8'(bus.txe_n), 8'h01);
`endif
        bus.data_in = 8'hEE;
        step();
        bus.wr_n = 1'b1;
`ifndef FTDI_EMU_THROTTLE_EN
        chk("overrun_set", 8'(err_overrun), 8'h01);
`endif
        host_rx_rdy = 1'b1;
        repeat (18) step();
        host_rx_rdy = 1'b0;

        for (int i = 0; i < 20; i++) begin
            host_tx_dv = 1'b1;
            host_tx_din = 8'($urandom);
            step();
        end
`ifndef FTDI_EMU_THROTTLE_EN
        chk("rx_full_rdy", 8'(host_tx_rdy), 8'h00);
`endif
        bus.oe_n = 1'b0;
        bus.rd_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            host_tx_din = 8'($urandom);
            step();
        end
        host_tx_dv = 1'b0;
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
        step();

        bus.rd_n = 1'b0;
        step();
        bus.rd_n = 1'b1;
`ifndef FTDI_EMU_THROTTLE_EN
        chk("rd_no_oe_set", 8'(err_rd_no_oe), 8'h01);
`endif

        bus.oe_n = 1'b0;
        bus.rd_n = 1'b0;
        bus.wr_n = 1'b0;
        host_tx_dv = 1'b1;
        repeat (2) step();
        reset = 1'b1;
        step();
`ifndef FTDI_EMU_THROTTLE_EN
        chk("rst_rxf", 8'(bus.rxf_n), 8'h01);
        chk("rst_txe", 8'(bus.txe_n), 8'h01);
        chk("rst_errs", 8'({err_underrun, err_overrun, err_rd_no_oe}), 8'h00);
`endif
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
        bus.wr_n = 1'b1;
        host_tx_dv = 1'b0;
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 1500; i++) begin
            host_tx_dv  = 1'($urandom_range(0, 1));
            host_tx_din = 8'($urandom);
            host_rx_rdy = 1'($urandom_range(0, 1));
            bus.oe_n    = ($urandom_range(0, 7) == 0);
            bus.rd_n    = 1'($urandom_range(0, 1));
            bus.wr_n    = 1'($urandom_range(0, 1));
            bus.data_in = 8'($urandom);
            step();
        end
        host_tx_dv = 1'b0;
        bus.rd_n = 1'b1;
        bus.oe_n = 1'b1;
        bus.wr_n = 1'b1;
        host_rx_rdy = 1'b1;
        repeat (TXD + 4) step();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
